// File: rtl/range_finder_cpu_debug_mem_access.sv
// Debug-command to Avalon-MM bridge: one single-word access per strobe, ready 2+ clk after the strobe.
// Waitrequest stalls hold the request stable until TIMEOUT aborts it; strobes arriving while busy are dropped.
module range_finder_cpu_debug_mem_access #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [16:0]       TMO_LIM  = 17'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_mon_d;
  logic [31:0]       r_wdata;
  logic              r_ready;
  logic              r_error;
  logic              r_incr;
  logic [15:0]       r_cnt;

  logic              w_start_rd;
  logic              w_start_wr;
  logic              w_load_addr;
  logic              w_clr_err;
  logic              w_set_incr;
  logic              w_done;
  logic              w_abort;
  logic              w_busy;
  logic              w_any_strobe;
  logic              w_set_err;
  logic [16:0]       w_cnt_p1;
  logic              w_unused;

  assign w_busy       = (r_state != IDLE);
  assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_cnt_p1     = {1'b0, r_cnt} + 17'd1;
  assign w_set_err    = w_abort | (w_busy & w_any_strobe);
  assign w_unused     = ^jdo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;
    w_load_addr = 1'b0;
    w_clr_err   = 1'b0;
    w_set_incr  = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (take_action_ocimem_b) begin
          w_start_wr  = 1'b1;
          w_set_incr  = 1'b1;
          w_state_nxt = WRITE;
        end else if (take_action_ocimem_a) begin
          w_load_addr = 1'b1;
          w_clr_err   = jdo[37];
          if (jdo[36]) begin
            w_start_rd  = 1'b1;
            w_state_nxt = READ;
          end
        end else if (take_no_action_ocimem_a) begin
          w_start_rd  = 1'b1;
          w_set_incr  = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ, WRITE: begin
        if (!avm_waitrequest) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_cnt_p1 == TMO_LIM) begin
          // the stall cycle that brings the count to TIMEOUT is the last one
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon_a <= '0;
      r_mon_d <= '0;
      r_wdata <= '0;
      r_ready <= 1'b1;
      r_error <= 1'b0;
      r_incr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_load_addr)         r_mon_a <= jdo[ADDR_W+1:2];
      else if (w_done && r_incr) r_mon_a <= r_mon_a + ADDR_ONE;

      if (w_start_wr) r_wdata <= jdo[31:0];

      if (w_start_rd || w_start_wr) begin
        r_ready <= 1'b0;
        r_cnt   <= '0;
        r_incr  <= w_set_incr;
      end else if (w_busy && avm_waitrequest) begin
        r_cnt   <= w_cnt_p1[15:0];
      end

      if (w_done || w_abort) r_ready <= 1'b1;
      if (w_done) r_mon_d <= (r_state == READ) ? avm_readdata : r_wdata;

      if (w_set_err)      r_error <= 1'b1;
      else if (w_clr_err) r_error <= 1'b0;
    end
  end

  assign avm_address   = {r_mon_a, 2'b00};
  assign avm_read      = (r_state == READ);
  assign avm_write     = (r_state == WRITE);
  assign avm_writedata = r_wdata;
  assign MonAReg       = r_mon_a;
  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule

// File: tb/tb_range_finder_cpu_debug_mem_access.sv
// Randomised bench for the debug memory-access bridge against a transaction-level model.
module tb_range_finder_cpu_debug_mem_access;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic [ADDR_W-1:0] MonAReg;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  always #5 clk = ~clk;

  range_finder_cpu_debug_mem_access #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_readdata           (avm_readdata),
    .avm_waitrequest        (avm_waitrequest),
    .MonAReg                (MonAReg),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: word address, data register, sticky error, last written data.
  logic [15:0] m_addr;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] m_wdata;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[37:0];
  endfunction

  function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [15:0] a);
    return {clr, rd, 4'h0, 14'h0, a, 2'b00};
  endfunction

  task automatic check_idle(input string tag);
    chk_eq({tag, "_rd"},    avm_read, 1'b0);
    chk_eq({tag, "_wr"},    avm_write, 1'b0);
    chk_eq({tag, "_ready"}, monitor_ready, 1'b1);
    chk_eq({tag, "_areg"},  MonAReg, m_addr);
    chk_eq({tag, "_dreg"},  MonDReg, m_data);
    chk_eq({tag, "_err"},   monitor_error, m_err);
    chk_eq({tag, "_wdata"}, avm_writedata, m_wdata);
  endtask

  // Issue one strobe set while idle, serve the resulting bus access with n_wait stall
  // cycles, optionally firing an ocimem_b strobe in busy cycle 'collide'.
  task automatic run_cmd(input string tag, input logic sa, input logic sna, input logic sb,
                         input logic [37:0] j, input int n_wait, input int collide);
    logic        rd, wr, incr, abort;
    logic [31:0] wd, rdv;
    logic [15:0] acc_addr;
    int          ncyc;
    rd = 1'b0; wr = 1'b0; incr = 1'b0; wd = j[31:0]; rdv = '0;
    if (sb) begin
      wr = 1'b1; incr = 1'b1;
    end else if (sa) begin
      m_addr = j[17:2];
      if (j[37]) m_err = 1'b0;
      rd = j[36];
    end else if (sna) begin
      rd = 1'b1; incr = 1'b1;
    end
    acc_addr = m_addr;

    @(negedge clk);
    jdo = j;
    take_action_ocimem_a    = sa;
    take_no_action_ocimem_a = sna;
    take_action_ocimem_b    = sb;
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo = rand_jdo();

    if (rd || wr) begin
      if (wr) m_wdata = wd;
      abort = (n_wait >= TIMEOUT);
      ncyc  = abort ? TIMEOUT : n_wait + 1;
      for (int i = 0; i < ncyc; i++) begin
        chk_eq({tag, "_req_rd"}, avm_read, rd);
        chk_eq({tag, "_req_wr"}, avm_write, wr);
        chk_eq({tag, "_addr"},   avm_address, {acc_addr, 2'b00});
        chk_eq({tag, "_busy"},   monitor_ready, 1'b0);
        chk_eq({tag, "_wdata"},  avm_writedata, m_wdata);
        avm_waitrequest = (i < n_wait);
        rdv = $urandom;
        avm_readdata = rdv;
        if (i == collide) begin
          take_action_ocimem_b = 1'b1;
          jdo = rand_jdo();
          m_err = 1'b1;
        end
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        avm_waitrequest = 1'b0;
      end
      if (abort) m_err = 1'b1;
      else begin
        m_data = rd ? rdv : wd;
        if (incr) m_addr = m_addr + 16'd1;
      end
    end
    check_idle(tag);
  endtask

  initial begin
    logic [2:0] s;
    int         col;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    reset_n = 1'b0;
    m_addr = '0; m_data = '0; m_err = 1'b0; m_wdata = '0;
    #12;
    chk_eq("rst_addr", avm_address, 18'h0);
    check_idle("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Address load + read at 0x0010 with 3 stall cycles -> byte address 0x40
    run_cmd("load_rd", 1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 16'h0010), 3, -1);
    chk_eq("load_rd_abs", MonAReg, 16'h0010);
    // Streaming writes from 0x0020
    run_cmd("ld20", 1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 16'h0020), 0, -1);
    run_cmd("wr1", 1'b0, 1'b0, 1'b1, {6'h0, 32'h11111111}, 0, -1);
    run_cmd("wr2", 1'b0, 1'b0, 1'b1, {6'h0, 32'h22222222}, 0, -1);
    chk_eq("stream_areg", MonAReg, 16'h0022);
    chk_eq("stream_dreg", MonDReg, 32'h22222222);
    // Wrap at top of the address space
    run_cmd("ldffff", 1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 16'hFFFF), 0, -1);
    run_cmd("wrap", 1'b0, 1'b1, 1'b0, rand_jdo(), 1, -1);
    chk_eq("wrap_areg", MonAReg, 16'h0000);
    // Timeout abort, then error clear
    run_cmd("ld7", 1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 16'h0007), 0, -1);
    run_cmd("tmo", 1'b0, 1'b1, 1'b0, rand_jdo(), 20, -1);
    chk_eq("tmo_err", monitor_error, 1'b1);
    chk_eq("tmo_areg", MonAReg, 16'h0007);
    run_cmd("clr", 1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 16'h0007), 0, -1);
    chk_eq("clr_err", monitor_error, 1'b0);
    // Write strobe while a read is stalled
    run_cmd("coll", 1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 16'h0005), 3, 1);
    chk_eq("coll_err", monitor_error, 1'b1);
    // Coincident strobes
    run_cmd("pri_all", 1'b1, 1'b1, 1'b1, rand_jdo(), 0, -1);
    run_cmd("pri_a", 1'b1, 1'b1, 1'b0, rand_jdo(), 1, -1);

    for (int n = 0; n < 120; n++) begin
      s = 3'($urandom_range(1, 7));
      col = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cmd("rnd", s[2], s[1], s[0], rand_jdo(), int'($urandom_range(0, 5)), col);
    end

    // Reset during a stalled write
    run_cmd("pre_rst", 1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 16'h1234), 0, -1);
    @(negedge clk);
    jdo = {6'h0, 32'hCAFEF00D};
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    avm_waitrequest = 1'b1;
    chk_eq("mid_wr", avm_write, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    m_addr = '0; m_data = '0; m_err = 1'b0; m_wdata = '0;
    chk_eq("mid_addr", avm_address, 18'h0);
    check_idle("mid_rst");
    @(negedge clk);
    avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
